// File: rtl/tsp16_pkg.sv
// Shared types for the tsp16 datapath. Decode and writeback both use the
// word and register-index types, and the register file takes its default
// geometry from here.
package tsp16_pkg;

  localparam int TSP_DATA_W   = 16;
  localparam int TSP_NUM_REGS = 8;

  typedef logic [TSP_DATA_W-1:0]            word_t;
  typedef logic [$clog2(TSP_NUM_REGS)-1:0]  reg_idx_t;

endpackage

// File: rtl/scoreboard_regfile_if.sv
// Bus between issue/decode, writeback and the scoreboarded register file.
//   master : pipeline side (drives write, issue and read addresses)
//   slave  : register file side (returns read data, ready, conflict, count)
// Read port k uses read_reg_num[k*AW +: AW] and read_data[k*DATA_W +: DATA_W].
interface scoreboard_regfile_if
  import tsp16_pkg::*;
#(
  parameter int DATA_W   = TSP_DATA_W,
  parameter int NUM_REGS = TSP_NUM_REGS,
  parameter int NUM_READ = 2
);

  localparam int AW = $clog2(NUM_REGS);

  logic                       write;
  logic [AW-1:0]              write_reg_num;
  logic [DATA_W-1:0]          write_data;
  logic                       issue;
  logic [AW-1:0]              issue_reg_num;
  logic [NUM_READ*AW-1:0]     read_reg_num;
  logic [NUM_READ*DATA_W-1:0] read_data;
  logic [NUM_READ-1:0]        read_ready;
  logic                       issue_conflict;
  logic [AW:0]                pending_count;

  modport master (
    output write, write_reg_num, write_data, issue, issue_reg_num, read_reg_num,
    input  read_data, read_ready, issue_conflict, pending_count
  );

  modport slave (
    input  write, write_reg_num, write_data, issue, issue_reg_num, read_reg_num,
    output read_data, read_ready, issue_conflict, pending_count
  );

endinterface

// File: rtl/scoreboard_regfile_reg_scoreboard.sv
// Per-register pending scoreboard.
//   clk, rst       : clock, async active-high reset
//   set_vec        : one-hot issue decode (zero register already masked)
//   clr_vec        : one-hot writeback decode (zero register already masked)
//   pending        : pending bit per register
//   issue_conflict : issue lands on a register that is already pending
//   pending_count  : registered population count of pending
module reg_scoreboard
  import tsp16_pkg::*;
#(
  parameter int NUM_REGS = TSP_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REGS-1:0]       set_vec,
  input  logic [NUM_REGS-1:0]       clr_vec,
  output logic [NUM_REGS-1:0]       pending,
  output logic                      issue_conflict,
  output logic [$clog2(NUM_REGS):0] pending_count
);

  localparam int CW = $clog2(NUM_REGS) + 1;

  logic [NUM_REGS-1:0] pend_nxt;
  logic [CW-1:0]       cnt_nxt;

  // Set after clear: an issue in the same cycle as writeback to the same
  // register means a newer producer is in flight, so the bit stays up.
  always_comb begin
    pend_nxt = (pending & ~clr_vec) | set_vec;
    cnt_nxt  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pend_nxt;
      pending_count <= cnt_nxt;
    end
  end

  assign issue_conflict = |(set_vec & pending);

endmodule

// File: rtl/scoreboard_regfile.sv
// Parametrised register file with async-cleared contents, optional hardwired
// zero register, same-cycle write-to-read bypass and a pending scoreboard.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of scoreboard_regfile_if (write, issue, read ports,
//              read_ready, issue_conflict, pending_count)
module scoreboard_regfile
  import tsp16_pkg::*;
#(
  parameter int DATA_W   = TSP_DATA_W,
  parameter int NUM_REGS = TSP_NUM_REGS,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  scoreboard_regfile_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] is_sel;
  logic [NUM_REGS-1:0] pending;

  // One-hot decode of write and issue destinations; register 0 is masked
  // out here so neither the data array nor the scoreboard ever touches it.
  always_comb begin
    wr_sel = '0;
    is_sel = '0;
    if (bus.write) wr_sel[bus.write_reg_num] = 1'b1;
    if (bus.issue) is_sel[bus.issue_reg_num] = 1'b1;
    if (ZERO_REG != 0) begin
      wr_sel[0] = 1'b0;
      is_sel[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) regs[i] <= bus.write_data;
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .set_vec        (is_sel),
    .clr_vec        (wr_sel),
    .pending        (pending),
    .issue_conflict (bus.issue_conflict),
    .pending_count  (bus.pending_count)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_zero;
    logic          hit;

    assign ra      = bus.read_reg_num[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    // Bypass is suppressed during reset so readers see the cleared state.
    assign hit     = (BYPASS != 0) && !rst && bus.write &&
                     (bus.write_reg_num == ra) && !is_zero;

    assign bus.read_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                               hit     ? bus.write_data : regs[ra];
    assign bus.read_ready[k] = is_zero | hit | ~pending[ra];
  end

endmodule
